// File: rtl/reg_stream_reader.sv
// Parallel-load, serial-read word buffer: captures N words of M bits in one
// cycle and streams them out word 0 first over a valid/ready handshake.
module reg_stream_reader #(
  parameter int M = 18,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [N*M-1:0] in_data,
  output logic           busy,
  output logic [M-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   index;
  logic [M-1:0]    buffer [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
      done  <= 1'b0;
      for (int i = 0; i < N; i++) buffer[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            for (int i = 0; i < N; i++) buffer[i] <= in_data[i*M +: M];
            index <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          // load is deliberately not looked at here: the buffer is frozen mid-stream
          if (out_ready) begin
            if (index == LAST_IDX) begin
              index <= '0;
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              index <= index + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on state and index, so out_ready never reaches them.
  assign out_valid = (state == SEND);
  assign busy      = out_valid;
  assign out_last  = out_valid && (index == LAST_IDX);
  assign out_data  = out_valid ? buffer[index] : '0;

endmodule

// File: tb/tb_reg_stream_reader.sv
// Self-checking bench for reg_stream_reader (M=18, N=4): directed scenarios
// plus a randomized run against a transaction-level reference model.
module tb_reg_stream_reader;

  localparam int M = 18;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load = 1'b0;
  logic [N*M-1:0] in_data = '0;
  logic           busy;
  logic [M-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           out_last;
  logic           done;

  int vectors = 0;
  int miscompares = 0;

  logic [21:0] obs;
  assign obs = {out_valid, busy, out_last, done, out_data};

  reg_stream_reader #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .load(load), .in_data(in_data), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  // Expected {valid, busy, last, done, data}; busy tracks valid, data zero when not valid.
  function automatic logic [21:0] exp_out(input bit v, input bit l, input bit d, input logic [17:0] w);
    return {v, v, l, d, (v ? w : 18'h0)};
  endfunction

  function automatic logic [71:0] pack(input logic [17:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [71:0] rnd_bus();
    logic [71:0] r;
    for (int i = 0; i < N; i++) r[i*M +: M] = 18'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    logic [21:0] e;
    #2;
    e = exp_out(0, 0, 0, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_held: got %h expected %h", obs, e); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_data = rnd_bus();
      @(negedge clk);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL reset_idle: got %h expected %h", obs, e); end
    end
  endtask

  task automatic test_single_stream();
    logic [17:0] w [4] = '{18'h00001, 18'h3FFFF, 18'h15555, 18'h2AAAA};
    logic [21:0] e;
    int busy_cycles = 0;
    @(negedge clk);
    out_ready = 1'b1; load = 1'b1; in_data = pack(w[0], w[1], w[2], w[3]);
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_data = rnd_bus();
      e = exp_out(1, i == N-1, 0, w[i]);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL single_word%0d: got %h expected %h", i, obs, e); end
      busy_cycles += int'(busy);
      @(negedge clk);
    end
    e = exp_out(0, 0, 1, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL single_done: got %h expected %h", obs, e); end
    busy_cycles += int'(busy);
    @(negedge clk);
    e = exp_out(0, 0, 0, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL single_idle: got %h expected %h", obs, e); end
    vectors++;
    if (busy_cycles !== 4) begin miscompares++; $display("FAIL single_busy_cycles: got %0d expected 4", busy_cycles); end
  endtask

  task automatic test_backpressure();
    logic [17:0] w [4] = '{18'h00001, 18'h3FFFF, 18'h15555, 18'h2AAAA};
    bit rdy [7] = '{1, 0, 0, 0, 1, 1, 1};
    logic [21:0] e;
    int k = 0;
    int valid_cycles = 0;
    @(negedge clk);
    load = 1'b1; in_data = pack(w[0], w[1], w[2], w[3]);
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c < 7; c++) begin
      e = exp_out(1, k == N-1, 0, w[k]);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL bp_cycle%0d: got %h expected %h", c, obs, e); end
      valid_cycles += int'(out_valid);
      out_ready = rdy[c];
      if (rdy[c]) k++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    e = exp_out(0, 0, 1, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL bp_done: got %h expected %h", obs, e); end
    vectors++;
    if (valid_cycles !== 7) begin miscompares++; $display("FAIL bp_valid_cycles: got %0d expected 7", valid_cycles); end
    @(negedge clk);
    e = exp_out(0, 0, 0, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL bp_idle: got %h expected %h", obs, e); end
  endtask

  task automatic test_load_ignored();
    logic [17:0] w [4];
    logic [21:0] e;
    for (int i = 0; i < N; i++) w[i] = 18'($urandom);
    @(negedge clk);
    out_ready = 1'b1; load = 1'b1; in_data = pack(w[0], w[1], w[2], w[3]);
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < N; i++) begin
      e = exp_out(1, i == N-1, 0, w[i]);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL ignore_word%0d: got %h expected %h", i, obs, e); end
      load = (i == 2);
      in_data = ~pack(w[0], w[1], w[2], w[3]);
      @(negedge clk);
    end
    load = 1'b0;
    e = exp_out(0, 0, 1, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL ignore_done: got %h expected %h", obs, e); end
    e = exp_out(0, 0, 0, 18'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL ignore_no_restart: got %h expected %h", obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] wa [4];
    logic [17:0] wb [4] = '{18'h00010, 18'h00011, 18'h00012, 18'h00013};
    logic [21:0] e;
    int dones = 0;
    for (int i = 0; i < N; i++) wa[i] = 18'($urandom);
    @(negedge clk);
    out_ready = 1'b1; load = 1'b1; in_data = pack(wa[0], wa[1], wa[2], wa[3]);
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < N; i++) begin
      e = exp_out(1, i == N-1, 0, wa[i]);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL b2b_a_word%0d: got %h expected %h", i, obs, e); end
      dones += int'(done);
      @(negedge clk);
    end
    e = exp_out(0, 0, 1, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_a_done: got %h expected %h", obs, e); end
    dones += int'(done);
    load = 1'b1; in_data = pack(wb[0], wb[1], wb[2], wb[3]);
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < N; i++) begin
      e = exp_out(1, i == N-1, 0, wb[i]);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL b2b_b_word%0d: got %h expected %h", i, obs, e); end
      dones += int'(done);
      @(negedge clk);
    end
    e = exp_out(0, 0, 1, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL b2b_b_done: got %h expected %h", obs, e); end
    dones += int'(done);
    @(negedge clk);
    dones += int'(done);
    vectors++;
    if (dones !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
  endtask

  task automatic test_reset_mid_stream();
    logic [17:0] w [4];
    logic [21:0] e;
    for (int i = 0; i < N; i++) w[i] = 18'($urandom) | 18'h20000;
    @(negedge clk);
    out_ready = 1'b1; load = 1'b1; in_data = pack(w[0], w[1], w[2], w[3]);
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = exp_out(1, 0, 0, w[i]);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rstmid_word%0d: got %h expected %h", i, obs, e); end
      @(negedge clk);
    end
    e = exp_out(1, 0, 0, w[2]);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rstmid_index2: got %h expected %h", obs, e); end
    rst = 1'b1;
    #1;
    e = exp_out(0, 0, 0, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rstmid_async_clear: got %h expected %h", obs, e); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rstmid_idle: got %h expected %h", obs, e); end
    end
    load = 1'b1; in_data = pack(18'h7, 18'h7, 18'h7, 18'h7);
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < N; i++) begin
      e = exp_out(1, i == N-1, 0, 18'h00007);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL rstmid_reload_word%0d: got %h expected %h", i, obs, e); end
      @(negedge clk);
    end
    e = exp_out(0, 0, 1, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rstmid_reload_done: got %h expected %h", obs, e); end
    @(negedge clk);
    e = exp_out(0, 0, 0, 18'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL rstmid_final_idle: got %h expected %h", obs, e); end
  endtask

  // Reference: a stream is a list of N captured words consumed one per accepted
  // handshake; done follows the handshake that consumes the last word.
  task automatic test_random();
    logic [17:0] words [$];
    logic [21:0] e;
    logic [71:0] d;
    int sent = 0;
    bit done_next = 0;
    bit r, l;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (words.size() != 0)
        e = exp_out(1, sent == N-1, done_next, words[sent]);
      else
        e = exp_out(0, 0, done_next, 18'h0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL random_cycle%0d: got %h expected %h", c, obs, e); end
      r = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      d = rnd_bus();
      out_ready = r; load = l; in_data = d;
      done_next = 0;
      if (words.size() != 0) begin
        if (r) begin
          sent++;
          if (sent == N) begin
            words.delete();
            sent = 0;
            done_next = 1;
          end
        end
      end else if (l) begin
        for (int i = 0; i < N; i++) words.push_back(d[i*M +: M]);
        sent = 0;
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_backpressure();
    test_load_ignored();
    test_back_to_back();
    test_reset_mid_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
